// File: rtl/mult_seq_ctrl_if.sv
// Control bus between the shift-add multiplier sequencer and its datapath
// (product register register_hl plus input muxes/adder).
interface mult_seq_ctrl_if #(
  parameter int N = 16
);
  localparam int SW = $clog2(N/2) + 1;

  // requests into the sequencer
  logic          start;
  logic          abort;
  logic          clr_req;
  logic          lsb;
  // controls out of the sequencer
  logic          prod_clear;
  logic          prod_loadh;
  logic          prod_loadl;
  logic          init_sel;
  logic          add_en;
  logic          busy;
  logic          done;
  logic [SW-1:0] step;

  // master: the sequencer
  modport master (
    input  start, abort, clr_req, lsb,
    output prod_clear, prod_loadh, prod_loadl, init_sel, add_en, busy, done, step
  );

  // slave: requester plus datapath side
  modport slave (
    output start, abort, clr_req, lsb,
    input  prod_clear, prod_loadh, prod_loadl, init_sel, add_en, busy, done, step
  );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Sequencer for the shift-add NxN/2 multiplier. Loads {0,B} into the product
// register, then runs N/2 add-and-shift steps, adding A into the high half
// whenever the product LSB (current multiplier bit) is set.
module mult_seq_ctrl #(
  parameter int N = 16
) (
  input  logic            i_clk,
  input  logic            i_reset,
  mult_seq_ctrl_if.master io_bus
);
  localparam int HALF = N / 2;
  localparam int SW   = $clog2(HALF) + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_RUN  = 3'd2,
    S_DONE = 3'd3,
    S_CLR  = 3'd4
  } state_t;

  state_t        r_state;
  logic [SW-1:0] r_step;
  logic          r_clear;
  logic          r_load;
  logic          r_init;
  logic          r_run;
  logic          r_busy;
  logic          r_done;
  logic          w_add_en;

  // State register; every output flag is registered alongside the state it
  // belongs to, so prod_clear leaves a flop with no decode glitches.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_step  <= '0;
      r_clear <= 1'b0;
      r_load  <= 1'b0;
      r_init  <= 1'b0;
      r_run   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_clear <= 1'b0;
      r_load  <= 1'b0;
      r_init  <= 1'b0;
      r_run   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          // start wins over clr_req
          if (io_bus.start) begin
            r_state <= S_INIT;
            r_load  <= 1'b1;
            r_init  <= 1'b1;
            r_busy  <= 1'b1;
          end else if (io_bus.clr_req) begin
            r_state <= S_CLR;
            r_clear <= 1'b1;
          end
        end
        S_INIT: begin
          if (io_bus.abort) begin
            r_state <= S_CLR;
            r_step  <= '0;
            r_clear <= 1'b1;
          end else begin
            r_state <= S_RUN;
            r_step  <= SW'(HALF);
            r_load  <= 1'b1;
            r_run   <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          if (io_bus.abort) begin
            r_state <= S_CLR;
            r_step  <= '0;
            r_clear <= 1'b1;
          end else if (r_step == SW'(1)) begin
            // last step has just been loaded
            r_state <= S_DONE;
            r_step  <= '0;
            r_done  <= 1'b1;
            r_busy  <= 1'b1;
          end else begin
            r_step  <= r_step - SW'(1);
            r_load  <= 1'b1;
            r_run   <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_DONE: begin
          if (io_bus.abort) begin
            r_state <= S_CLR;
            r_clear <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CLR: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_step  <= '0;
        end
      endcase
    end
  end

  // add_en follows the live multiplier bit during RUN only
  always_comb begin
    w_add_en = r_run & io_bus.lsb;
  end

  assign io_bus.prod_clear = r_clear;
  assign io_bus.prod_loadh = r_load;
  assign io_bus.prod_loadl = r_load;
  assign io_bus.init_sel   = r_init;
  assign io_bus.add_en     = w_add_en;
  assign io_bus.busy       = r_busy;
  assign io_bus.done       = r_done;
  assign io_bus.step       = r_step;

`ifndef SYNTHESIS
  // Sanity: clear never overlaps a busy cycle and RUN always has steps left.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      assert (!(r_clear && r_busy));
      assert (!(r_state == S_RUN && r_step == '0));
    end
  end
`endif
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench: stimulus pushes expected events (completion with product,
// multiplier-bit pattern and cycle, or a clear pulse with its cycle); a monitor
// pops and compares whenever done or prod_clear appears.
module tb_mult_seq_ctrl;
  localparam int N    = 16;
  localparam int HALF = N / 2;
  localparam int SW   = $clog2(HALF) + 1;

  typedef struct {
    bit          is_done;
    logic [15:0] prod;
    logic [7:0]  pat;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  // datapath model state
  logic [7:0]  A = '0;
  logic [7:0]  B = '0;
  logic [15:0] P = '0;
  logic [8:0]  sum;

  mult_seq_ctrl_if #(.N(N)) bus ();

  mult_seq_ctrl #(.N(N)) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .io_bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // shift-add product register driven by the sequencer controls
  always @(posedge clk) begin
    if (bus.prod_clear) P <= '0;
    else if (bus.prod_loadh) begin
      if (bus.init_sel) P <= {8'h00, B};
      else begin
        sum = {1'b0, P[15:8]} + (bus.add_en ? {1'b0, A} : 9'd0);
        P <= {sum, P[7:1]};
      end
    end
  end
  assign bus.lsb = P[0];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // monitor
  logic [7:0] pat;
  int         npat;
  bit         pc_prev, chk_zero;
  exp_t       e;
  always @(negedge clk) begin
    if (rst) begin
      pc_prev = 0; chk_zero = 0; npat = 0; pat = '0;
    end else begin
      chk("load_equal", bus.prod_loadh, bus.prod_loadl);
      if (chk_zero) begin chk("clear_product", P, 16'h0); chk_zero = 0; end
      if (bus.prod_clear) chk("clear_width", pc_prev, 1'b0);
      if (bus.init_sel) begin pat = '0; npat = 0; end
      else if (bus.prod_loadh) begin
        if (npat < HALF) pat[npat] = bus.add_en;
        npat++;
      end
      if (bus.done || bus.prod_clear) begin
        if (sb.size() == 0) chk("unexpected_event", {bus.done, bus.prod_clear}, 2'b00);
        else begin
          e = sb.pop_front();
          chk("event_kind", bus.done, e.is_done);
          chk("event_cycle", cyc + 1, e.cyc);
          if (e.is_done) begin
            chk("product", P, e.prod);
            chk("add_en_pattern", pat, e.pat);
            chk("run_cycles", npat, HALF);
          end else begin
            chk("clear_busy", bus.busy, 1'b0);
            chk_zero = 1;
          end
        end
      end
      pc_prev = bus.prod_clear;
    end
  end

  // called at a negedge; start is sampled at the next edge k
  task automatic do_mult(input logic [7:0] a, input logic [7:0] b, output int k);
    A = a; B = b;
    bus.start = 1'b1;
    k = cyc + 1;
    sb.push_back('{1'b1, 16'(a * b), b, k + 2 + HALF});
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_rise", bus.busy, 1'b1);
  endtask

  task automatic wait_empty(string tag);
    int n = 0;
    while (sb.size() != 0 && n < 40) begin @(negedge clk); n++; end
    chk({tag, "_timeout"}, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int k, ka, k2;
    logic [7:0] a2, b2;
    bus.start = 0; bus.abort = 0; bus.clr_req = 0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {bus.prod_clear, bus.prod_loadh, bus.prod_loadl, bus.init_sel,
                          bus.add_en, bus.busy, bus.done}, 7'h0);
    chk("reset_step", bus.step, 0);
    rst = 1'b0;
    @(negedge clk);

    // directed products
    do_mult(8'd13, 8'd11, k);  wait_empty("m13x11");
    do_mult(8'd255, 8'd255, k); wait_empty("m255x255");
    do_mult(8'd200, 8'd0, k);  wait_empty("m200x0");

    // abort in the 3rd RUN cycle, restart 2 cycles later
    do_mult(8'd77, 8'd93, k);
    while (cyc < k + 3) @(negedge clk);
    bus.abort = 1'b1;
    ka = cyc + 1;
    void'(sb.pop_back());
    sb.push_back('{1'b0, 16'h0, 8'h0, ka + 1});
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_busy_fall", bus.busy, 1'b0);
    @(negedge clk);
    do_mult(8'd9, 8'd7, k);
    wait_empty("after_abort");

    // start held through DONE: back-to-back at minimum spacing
    a2 = 8'($urandom_range(0, 255)); b2 = 8'($urandom_range(0, 255));
    do_mult(8'd21, 8'd170, k);
    bus.start = 1'b1;
    k2 = k + HALF + 3;
    sb.push_back('{1'b1, 16'(a2 * b2), b2, k2 + 2 + HALF});
    while (cyc < k2 - 1) @(negedge clk);
    A = a2; B = b2;
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_init", bus.init_sel, 1'b1);
    wait_empty("back_to_back");

    // start re-pulse during RUN ignored, then reset mid-RUN
    do_mult(8'd100, 8'd201, k);
    @(negedge clk); @(negedge clk);
    chk("step_run2", bus.step, HALF - 1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("restart_ignored_step", bus.step, HALF - 2);
    chk("restart_ignored_init", bus.init_sel, 1'b0);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("midrun_reset_outputs", {bus.prod_clear, bus.prod_loadh, bus.prod_loadl, bus.init_sel,
                                 bus.add_en, bus.busy, bus.done}, 7'h0);
    chk("midrun_reset_step", bus.step, 0);
    rst = 1'b0;
    @(negedge clk);

    // clr_req together with start: INIT wins, no clear
    A = 8'd6; B = 8'd43;
    bus.start = 1'b1; bus.clr_req = 1'b1;
    k = cyc + 1;
    sb.push_back('{1'b1, 16'(6 * 43), 8'd43, k + 2 + HALF});
    @(negedge clk);
    bus.start = 1'b0; bus.clr_req = 0;
    chk("start_over_clr", bus.init_sel, 1'b1);
    wait_empty("start_clr");

    // clr_req alone
    bus.clr_req = 1'b1;
    sb.push_back('{1'b0, 16'h0, 8'h0, cyc + 2});
    @(negedge clk);
    bus.clr_req = 1'b0;
    wait_empty("clr_only");
    @(negedge clk);

    // random operands with random gaps
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_mult(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), k);
      wait_empty("random");
    end
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
